// File: rtl/ft2232h_rx_reader.sv
// FT245 synchronous-FIFO receive engine: drains bytes from the FT2232H into a
// first-word-fall-through FIFO and presents them on a valid/ready byte stream.
module ft2232h_rx_reader #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned STOP_MARGIN = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rxf_n_i,
  input  logic [7:0]  adbus_i,
  output logic        oe_n_o,
  output logic        rd_n_o,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        overflow_o,
  output logic [31:0] rx_count_o
);

  localparam int unsigned Aw = $clog2(DEPTH);
  localparam logic [Aw:0] DepthW = (Aw + 1)'(DEPTH);
  localparam logic [Aw:0] StopW  = (Aw + 1)'(STOP_MARGIN);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StTurn = 2'd1;
  localparam logic [1:0] StRead = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          oe_n_q, oe_n_d;
  logic          rd_n_q, rd_n_d;
  logic [Aw:0]   count_q, count_d;
  logic [Aw-1:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]    mem_q [DEPTH];
  logic          overflow_q;
  logic [31:0]   rx_count_q;

  logic room, full, capture, pop, push, drop;

  assign full    = (count_q == DepthW);
  assign room    = ((DepthW - count_q) > StopW);
  // The chip hands over a byte on every edge where both strobes are asserted,
  // including the edge on which the FSM leaves READ.
  assign capture = !rd_n_q && !rxf_n_i;
  assign pop     = valid_o && ready_i;
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_comb begin
    state_d = state_q;
    oe_n_d  = 1'b1;
    rd_n_d  = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (!rxf_n_i && room) begin
          state_d = StTurn;
          oe_n_d  = 1'b0;
        end
      end
      StTurn, StRead: begin
        if (rxf_n_i || !room) begin
          state_d = StIdle;
        end else begin
          state_d = StRead;
          oe_n_d  = 1'b0;
          rd_n_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      oe_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      rx_count_q <= '0;
    end else begin
      state_q <= state_d;
      oe_n_q  <= oe_n_d;
      rd_n_q  <= rd_n_d;
      count_q <= count_d;
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        rx_count_q <= rx_count_q + 32'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wr_ptr_q] <= adbus_i;
    end
  end

  assign oe_n_o     = oe_n_q;
  assign rd_n_o     = rd_n_q;
  assign valid_o    = (count_q != '0);
  assign data_o     = valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign overflow_o = overflow_q;
  assign rx_count_o = rx_count_q;

endmodule

// File: tb/tb_ft2232h_rx_reader.sv
// Bench for ft2232h_rx_reader: an FT2232H chip model feeds bytes, a queue-based
// FIFO model predicts the stream, pins are checked against the handshake rules.
module tb_ft2232h_rx_reader;

  localparam int unsigned Depth  = 16;
  localparam int unsigned Margin = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxf_n;
  logic        ready;
  logic [7:0]  adbus;
  logic        oe_n, rd_n, valid, ovf;
  logic [7:0]  data;
  logic [31:0] rx_count;
  logic        oe_n0, rd_n0, valid0, ovf0;
  logic [7:0]  data0;
  logic [31:0] rx_count0;

  always #5 clk = ~clk;

  ft2232h_rx_reader #(.DEPTH(Depth), .STOP_MARGIN(Margin)) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rxf_n_i    (rxf_n),
    .adbus_i    (adbus),
    .oe_n_o     (oe_n),
    .rd_n_o     (rd_n),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .overflow_o (ovf),
    .rx_count_o (rx_count)
  );

  // Zero stop margin makes the full-FIFO drop path reachable.
  ft2232h_rx_reader #(.DEPTH(Depth), .STOP_MARGIN(0)) u_dut_nomargin (
    .clk_i      (clk),
    .rst_i      (rst),
    .rxf_n_i    (rxf_n),
    .adbus_i    (adbus),
    .oe_n_o     (oe_n0),
    .rd_n_o     (rd_n0),
    .data_o     (data0),
    .valid_o    (valid0),
    .ready_i    (ready),
    .overflow_o (ovf0),
    .rx_count_o (rx_count0)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  chip_q[$];
  logic [7:0]  mdl[$];
  int unsigned exp_rx;
  logic        exp_ovf;
  int          ready_mode;
  int unsigned gap_pct;
  int unsigned m_cnt;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, check, advance the models.
  task automatic cycle();
    logic pre_rst, pre_rxf, pre_oe, pre_rd, has_room, cap, pop;
    logic [1:0] exp_pins;
    logic [7:0] b;
    ready = (ready_mode == 2) ? 1'($urandom_range(1)) : (ready_mode == 1);
    rxf_n = (chip_q.size() == 0) || ($urandom_range(99) < gap_pct);
    adbus = (chip_q.size() != 0) ? chip_q[0] : 8'($urandom);
    chk("valid", 32'(valid), 32'(mdl.size() != 0));
    if (mdl.size() != 0) chk("data", 32'(data), 32'(mdl[0]));
    chk("rx_count", rx_count, exp_rx);
    chk("overflow", 32'(ovf), 32'(exp_ovf));
    if (!rd_n) chk("oe_with_rd", 32'(oe_n), 32'd0);
    pre_rst  = rst;
    pre_rxf  = rxf_n;
    pre_oe   = oe_n;
    pre_rd   = rd_n;
    has_room = (Depth - mdl.size()) > Margin;
    if (pre_rst || pre_rxf || !has_room) exp_pins = 2'b11;
    else if (pre_oe)                     exp_pins = 2'b01;
    else                                 exp_pins = 2'b00;
    cap = !pre_rd && !pre_rxf;
    pop = (mdl.size() != 0) && ready;
    @(posedge clk);
    b = 8'h00;
    if (cap) b = chip_q.pop_front();
    if (pre_rst) begin
      mdl.delete();
      exp_rx  = 0;
      exp_ovf = 1'b0;
    end else begin
      if (pop) void'(mdl.pop_front());
      if (cap) begin
        if (mdl.size() < Depth) begin
          mdl.push_back(b);
          exp_rx++;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
    @(negedge clk);
    chk("oe_n", 32'(oe_n), 32'(exp_pins[1]));
    chk("rd_n", 32'(rd_n), 32'(exp_pins[0]));
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((chip_q.size() != 0 || mdl.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_drained"}, 32'(chip_q.size() + mdl.size()), 32'd0);
    cycle();
    cycle();
  endtask

  task automatic do_reset();
    chip_q.delete();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic cap0;
    rst = 1'b1; rxf_n = 1'b1; ready = 1'b0; adbus = 8'h00;
    ready_mode = 0; gap_pct = 0; exp_rx = 0; exp_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_oe_n", 32'(oe_n), 32'd1);
    chk("rst_rd_n", 32'(rd_n), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_overflow", 32'(ovf), 32'd0);
    chk("rst_rx_count", rx_count, 32'd0);
    rst = 1'b0;

    // 1: continuous burst 0x00..0x3F with a ready consumer.
    for (int i = 0; i < 64; i++) chip_q.push_back(8'(i));
    ready_mode = 1; gap_pct = 0;
    cycle();
    chk("t1_turnaround", 32'({oe_n, rd_n}), 32'd1);
    cycle();
    chk("t1_read", 32'({oe_n, rd_n}), 32'd0);
    drain("t1", 200);
    chk("t1_rx_count", rx_count, 32'd64);
    chk("t1_overflow", 32'(ovf), 32'd0);

    // 2: stalled consumer fills the FIFO up to the stop margin.
    do_reset();
    for (int i = 0; i < 40; i++) chip_q.push_back(8'($urandom));
    ready_mode = 0;
    for (int i = 0; i < 40; i++) cycle();
    chk("t2_rd_released", 32'(rd_n), 32'd1);
    chk("t2_level", 32'(mdl.size() >= Depth - Margin && mdl.size() <= Depth), 32'd1);
    chk("t2_no_drop", 32'(ovf), 32'd0);
    ready_mode = 1;
    drain("t2", 300);
    chk("t2_rx_count", rx_count, 32'd40);

    // 3: chip runs dry after five bytes.
    do_reset();
    for (int i = 0; i < 5; i++) chip_q.push_back(8'($urandom));
    drain("t3", 50);
    chk("t3_rx_count", rx_count, 32'd5);
    chk("t3_idle", 32'({oe_n, rd_n}), 32'd3);

    // 4: reset mid-burst with three bytes buffered.
    do_reset();
    for (int i = 0; i < 20; i++) chip_q.push_back(8'($urandom));
    ready_mode = 0;
    for (int i = 0; i < 20 && mdl.size() != 3; i++) cycle();
    chk("t4_buffered", 32'(mdl.size()), 32'd3);
    chk("t4_in_read", 32'(rd_n), 32'd0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t4_rst_rd_n", 32'(rd_n), 32'd1);
    chk("t4_rst_oe_n", 32'(oe_n), 32'd1);
    chk("t4_rst_valid", 32'(valid), 32'd0);
    chk("t4_rst_rx_count", rx_count, 32'd0);
    chip_q.delete();
    chip_q.push_back(8'hA5);
    chip_q.push_back(8'h5A);
    ready_mode = 1;
    drain("t4", 50);
    chk("t4_rx_count", rx_count, 32'd2);

    // 5: random bytes, random gaps, random backpressure.
    do_reset();
    for (int i = 0; i < 1000; i++) chip_q.push_back(8'($urandom));
    ready_mode = 2; gap_pct = 30;
    drain("t5", 20000);
    chk("t5_rx_count", rx_count, 32'd1000);
    chk("t5_overflow", 32'(ovf), 32'd0);

    // 6: no stop margin and no consumer: bytes past DEPTH are dropped.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; ready = 1'b0; rxf_n = 1'b0;
    m_cnt = 0; m_ovf = 1'b0;
    for (int i = 0; i < 40; i++) begin
      adbus = 8'(i);
      chk("t6_overflow", 32'(ovf0), 32'(m_ovf));
      chk("t6_rx_count", rx_count0, m_cnt);
      cap0 = !rd_n0;
      @(posedge clk);
      @(negedge clk);
      if (cap0) begin
        if (m_cnt == Depth) m_ovf = 1'b1;
        else                m_cnt++;
      end
    end
    chk("t6_sticky", 32'(ovf0), 32'd1);
    chk("t6_final_count", rx_count0, Depth);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
